// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared Galois LFSR step function and checker state encoding
package lfsr_pkg;
    localparam int STEP_W = 64;

    typedef enum logic [1:0] {SEARCH = 2'd0, SYNC = 2'd1, LOCK = 2'd2} chk_state_e;

    // Operands are zero-extended to STEP_W; w is the real word width (<= STEP_W)
    function automatic logic [STEP_W-1:0] galois_step(input logic [STEP_W-1:0] q,
                                                      input logic [STEP_W-1:0] poly,
                                                      input int unsigned w);
        logic [STEP_W-1:0] m;
        m = (STEP_W'(1) << (w - 1)) - STEP_W'(1);
        return ((q >> 1) ^ (poly & m & {STEP_W{q[0]}})) | (STEP_W'(q[0]) << (w - 1));
    endfunction
endpackage

// File: rtl/lfsr_galois_chk_sat_cnt.sv
// sat_cnt: saturating up-counter with synchronous clear taking priority over increment
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i)
            r_cnt <= '0;
        else if (clr_i)
            r_cnt <= '0;
        else if (inc_i && r_cnt != '1)
            r_cnt <= r_cnt + 1'b1;

    assign cnt_o = r_cnt;
endmodule

// File: rtl/lfsr_galois_chk.sv
// lfsr_galois_chk: self-synchronising checker for a Galois LFSR word stream
module lfsr_galois_chk
    import lfsr_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] POLY       = '0,
    parameter int                    LOCK_CNT   = 8,
    parameter int                    LOST_CNT   = 4,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  vld_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  clr_i,
    input  logic                  resync_i,
    output logic                  lock_o,
    output logic                  err_o,
    output logic [CNT_WIDTH-1:0]  err_cnt_o,
    output logic [1:0]            state_o
);
    localparam int MX = LOCK_CNT > LOST_CNT ? LOCK_CNT : LOST_CNT;
    localparam int CW = $clog2(MX) + 1;

    chk_state_e            r_state;
    logic [DATA_WIDTH-1:0] r_ref;
    logic [CW-1:0]         r_match;
    logic [CW-1:0]         r_bad;
    logic                  r_lock;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] w_step;
    logic                  w_hit;
    logic                  w_inc;

    assign w_step = DATA_WIDTH'(galois_step(STEP_W'(r_ref), STEP_W'(POLY), DATA_WIDTH));
    assign w_hit  = dat_i == w_step;
    // A counted error needs an accepted, non-overridden word while locked
    assign w_inc  = vld_i && !resync_i && r_state == LOCK && !w_hit;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            r_state <= SEARCH;
            r_ref   <= '0;
            r_match <= '0;
            r_bad   <= '0;
            r_lock  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_inc;
            if (resync_i) begin
                r_state <= SEARCH;
                r_match <= '0;
                r_bad   <= '0;
                r_lock  <= 1'b0;
            end else if (vld_i) begin
                case (r_state)
                    SEARCH:
                        if (dat_i != '0) begin
                            r_ref   <= dat_i;
                            r_match <= '0;
                            r_state <= SYNC;
                        end
                    SYNC: begin
                        r_ref <= dat_i;
                        if (w_hit) begin
                            if (r_match == CW'(LOCK_CNT - 1)) begin
                                r_state <= LOCK;
                                r_lock  <= 1'b1;
                                r_bad   <= '0;
                            end else
                                r_match <= r_match + 1'b1;
                        end else begin
                            r_match <= '0;
                            if (dat_i == '0)
                                r_state <= SEARCH;
                        end
                    end
                    LOCK: begin
                        r_ref <= w_step;
                        if (w_hit)
                            r_bad <= '0;
                        else if (r_bad == CW'(LOST_CNT - 1)) begin
                            r_state <= SEARCH;
                            r_lock  <= 1'b0;
                            r_bad   <= '0;
                        end else
                            r_bad <= r_bad + 1'b1;
                    end
                    default: begin
                        r_state <= SEARCH;
                        r_lock  <= 1'b0;
                    end
                endcase
            end
        end

    sat_cnt #(.W(CNT_WIDTH)) u_err_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_inc),
        .clr_i (clr_i),
        .cnt_o (err_cnt_o)
    );

    assign lock_o  = r_lock;
    assign err_o   = r_err;
    assign state_o = r_state;
endmodule
